mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single byte-wide external memory bus between two 16-bit requesters: the CPU `control_unit` (port 0) and a DMA/peripheral master (port 1). Round-robin arbitration selects one requester per transaction. Double-byte requests are split into two little-endian byte cycles. A bus watchdog terminates stalled accesses with an error. It sits between `control_unit`'s `mem_*` interface and the memory/bus-wrapper.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum wait cycles for `bus_ack` per byte before abort; range 1..65535.
- `clk`  in  1  system clock, rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `cpu_addr` / `dma_addr`  in  16  request byte address.
- `cpu_wdata` / `dma_wdata`  in  16  write data; `[7:0]` goes to addr, `[15:8]` to addr+1.
- `cpu_dbl_byte_en` / `dma_dbl_byte_en`  in  1  1 = 16-bit access, 0 = 8-bit access.
- `cpu_write_en` / `dma_write_en`  in  1  write request; held until the matching ack.
- `cpu_read_en` / `dma_read_en`  in  1  read request; held until the matching ack.
- `cpu_rdata` / `dma_rdata`  out  16  read data; valid in the ack cycle; 8-bit reads zero-extend.
- `cpu_ack` / `dma_ack`  out  1  one-cycle completion pulse.
- `bus_err`  out  1  one-cycle pulse with the ack of a timed-out transaction.
- `bus_addr`  out  16  external byte address.
- `bus_wdata`  out  8  external write byte.
- `bus_we` / `bus_re`  out  1  external strobes, held until `bus_ack`.
- `bus_rdata`  in  8  external read byte; sampled when `bus_ack` = 1.
- `bus_ack`  in  1  external byte completion.

## Operation
- Requester r is pending when `r_write_en | r_read_en`. If both are set, the access is a write.
- State machine, encoded in `arb_pkg::arb_state_t`:
  - IDLE: waits for a pending requester.
  - LO: first byte at `addr`.
  - HI: second byte at `addr+1`.
  - ACK: ack pulse to the owner.
- Arbitration (evaluated in IDLE only):
  - One requester pending: it is granted.
  - Both pending: the requester not granted last is granted.
  - Reset value of the last-grant pointer = DMA, so the CPU wins the first tie.
- On grant, the arbiter latches `owner`, `addr`, `wdata`, `dbl`, `is_write`. Requester inputs are ignored until the next IDLE.
- LO: drive `bus_addr`=addr, `bus_wdata`=wdata[7:0], and the strobe.
  - On `bus_ack`: reads capture `bus_rdata` into rdata[7:0].
  - Next state is HI if dbl, else ACK.
- HI: drive `bus_addr`=addr+1 (16-bit wrap: 0xFFFF→0x0000), `bus_wdata`=wdata[15:8].
  - On `bus_ack`: capture rdata[15:8]; next state is ACK.
- ACK:
  - Owner's ack = 1 for exactly one cycle; the other ack = 0.
  - Owner's rdata = latched data. The non-owner rdata holds its previous value.
  - Next state is IDLE.
- Watchdog:
  - Counter clears on entry to LO and to HI, and increments each cycle without `bus_ack`.
  - When the count reaches `TIMEOUT_CYCLES`, drop the strobes and go to ACK.
  - Read data = 0xFFFF (the byte already captured is discarded). `bus_err` = 1 in that ACK cycle.
- `bus_we`/`bus_re` are decoded from registered state only, and are never both 1.
- Reset values: all ack/strobe/err outputs 0; `bus_addr`, `bus_wdata`, both rdata = 0; state IDLE; pointer = DMA; counter = 0.
- Reset mid-transaction: the arbiter enters IDLE immediately (async). Strobes drop in the same instant, and no ack is issued.

## Timing
- Request visible in IDLE at cycle 0 → LO from edge 1.
- 8-bit access with `bus_ack` in the first LO cycle: ack in cycle 2 (latency 2).
- 16-bit access with zero-wait memory: ack in cycle 3.
- Each bus wait cycle adds 1 cycle of latency.
- Minimum 1 IDLE cycle between transactions. A requester that keeps its request asserted after ack (next instruction fetch) is re-arbitrated in that IDLE cycle.
- `bus_ack` is ignored in IDLE and ACK.
- `bus_ack` arriving in the same cycle the counter hits the limit counts as success; no error is raised.

## Structure
- `arb_pkg.sv`:
  - `arb_state_t` enum {IDLE, LO, HI, ACK}.
  - `arb_owner_t` enum {OWNER_CPU, OWNER_DMA}.
  - Width function for the timeout counter.
- Sub-module `mem_arb_timer`: parameterised watchdog counter.
  - Inputs: `clear`, `enable`, `bus_ack`.
  - Output: `expired`.
- The top level contains the arbitration, the FSM and the data/address latches.

## Test plan
- CPU 8-bit read of 0x1000, bus returns 0x3E with zero wait → `cpu_ack` in cycle 2, `cpu_rdata` = 0x003E, `dma_ack` = 0.
- CPU 16-bit write of 0x1003 at 0xFEFE:
  - Bus sees write 0x03 @0xFEFE, then 0x10 @0xFEFF.
  - One `cpu_ack`, 3 cycles after the request.
- Both requesters reading continuously:
  - Grants alternate CPU, DMA, CPU, …, with the first tie going to the CPU.
  - Each ack pulses once and is separated from the next by an IDLE cycle.
- DMA 16-bit read at 0xFFFF:
  - Second byte read from 0x0000.
  - Bytes 0x22 then 0x43 → `dma_rdata` = 0x4322.
- `TIMEOUT_CYCLES` = 4, bus never acks a CPU read:
  - Strobe is high for 4 cycles, then drops.
  - `cpu_ack` and `bus_err` pulse together; `cpu_rdata` = 0xFFFF.
- `nrst` asserted in the HI state of a 16-bit write:
  - `bus_we` drops immediately; no ack is issued.
  - After release, the first tie grants the CPU.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the two-port byte-bus arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        ACK
    } arb_state_t;

    typedef enum logic {
        OWNER_CPU,
        OWNER_DMA
    } arb_owner_t;

    // Bits needed to hold values 0..max_count-1 (never less than one bit).
    function automatic int cnt_width(input int max_count);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < 32'(max_count)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Bus watchdog: down-counter loaded on clear, expires when a strobed byte
// has waited TIMEOUT_CYCLES cycles without bus_ack.
module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic enable,
    input  logic bus_ack,
    output logic expired
);
    import arb_pkg::*;

    localparam int             W    = cnt_width(TIMEOUT_CYCLES);
    localparam logic [W-1:0]   LOAD = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tc;

    assign tc = (cnt_q == '0);

    // An ack in the terminal cycle wins over expiry.
    assign expired = enable && !bus_ack && tc;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = LOAD;
        end else if (enable && !bus_ack && !tc) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the byte-wide external bus between the CPU
// (port 0) and a DMA master (port 1); 16-bit accesses become two byte cycles.
module mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_dbl_byte_en,
    input  logic        cpu_write_en,
    input  logic        cpu_read_en,
    output logic [15:0] cpu_rdata,
    output logic        cpu_ack,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    input  logic        dma_dbl_byte_en,
    input  logic        dma_write_en,
    input  logic        dma_read_en,
    output logic [15:0] dma_rdata,
    output logic        dma_ack,
    output logic        bus_err,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_ack
);
    import arb_pkg::*;

    arb_state_t  state_q, state_d;
    arb_owner_t  owner_q, owner_d;
    arb_owner_t  last_q, last_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        dbl_q, dbl_d;
    logic        wr_q, wr_d;
    logic [7:0]  rlo_q, rlo_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dma_rdata_q, dma_rdata_d;
    logic        err_q, err_d;

    logic        cpu_pend, dma_pend, grant_dma;
    logic        fin;
    logic [15:0] fin_data;
    logic        expired, tmr_clear, tmr_enable;

    assign cpu_pend  = cpu_write_en | cpu_read_en;
    assign dma_pend  = dma_write_en | dma_read_en;
    assign grant_dma = dma_pend && (!cpu_pend || (last_q == OWNER_CPU));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        dbl_d       = dbl_q;
        wr_d        = wr_q;
        rlo_d       = rlo_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        err_d       = 1'b0;
        fin         = 1'b0;
        fin_data    = 16'h0000;

        case (state_q)
            IDLE: begin
                if (cpu_pend || dma_pend) begin
                    owner_d = grant_dma ? OWNER_DMA : OWNER_CPU;
                    last_d  = owner_d;
                    addr_d  = grant_dma ? dma_addr        : cpu_addr;
                    wdata_d = grant_dma ? dma_wdata       : cpu_wdata;
                    dbl_d   = grant_dma ? dma_dbl_byte_en : cpu_dbl_byte_en;
                    wr_d    = grant_dma ? dma_write_en    : cpu_write_en;
                    state_d = LO;
                end
            end
            LO: begin
                if (bus_ack) begin
                    rlo_d = bus_rdata;
                    if (dbl_q) begin
                        state_d = HI;
                    end else begin
                        state_d  = ACK;
                        fin      = 1'b1;
                        fin_data = {8'h00, bus_rdata};
                    end
                end else if (expired) begin
                    state_d  = ACK;
                    err_d    = 1'b1;
                    fin      = 1'b1;
                    fin_data = 16'hFFFF;
                end
            end
            HI: begin
                if (bus_ack) begin
                    state_d  = ACK;
                    fin      = 1'b1;
                    fin_data = {bus_rdata, rlo_q};
                end else if (expired) begin
                    state_d  = ACK;
                    err_d    = 1'b1;
                    fin      = 1'b1;
                    fin_data = 16'hFFFF;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Only reads deliver data; the other port keeps its last value.
        if (fin && !wr_q) begin
            if (owner_q == OWNER_CPU) begin
                cpu_rdata_d = fin_data;
            end else begin
                dma_rdata_d = fin_data;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_CPU;
            last_q      <= OWNER_DMA;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            dbl_q       <= 1'b0;
            wr_q        <= 1'b0;
            rlo_q       <= 8'h00;
            cpu_rdata_q <= 16'h0000;
            dma_rdata_q <= 16'h0000;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            dbl_q       <= dbl_d;
            wr_q        <= wr_d;
            rlo_q       <= rlo_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            err_q       <= err_d;
        end
    end

    assign tmr_clear  = (state_d != state_q);
    assign tmr_enable = (state_q == LO) || (state_q == HI);

    mem_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (tmr_clear),
        .enable  (tmr_enable),
        .bus_ack (bus_ack),
        .expired (expired)
    );

    // Bus side is decoded purely from registered state.
    always_comb begin
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        case (state_q)
            LO: begin
                bus_addr  = addr_q;
                bus_wdata = wdata_q[7:0];
            end
            HI: begin
                bus_addr  = addr_q + 16'd1;
                bus_wdata = wdata_q[15:8];
            end
            default: begin
                bus_addr  = 16'h0000;
                bus_wdata = 8'h00;
            end
        endcase
    end

    assign bus_we    = tmr_enable && wr_q;
    assign bus_re    = tmr_enable && !wr_q;
    assign bus_err   = err_q;
    assign cpu_ack   = (state_q == ACK) && (owner_q == OWNER_CPU);
    assign dma_ack   = (state_q == ACK) && (owner_q == OWNER_DMA);
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expected acks,
// a monitor pops and compares on every ack; a byte-memory model serves the bus.
module tb_mem_arbiter;

    logic        clk, nrst;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_dbl_byte_en, cpu_write_en, cpu_read_en;
    logic        dma_dbl_byte_en, dma_write_en, dma_read_en;
    logic [15:0] cpu_rdata, dma_rdata;
    logic        cpu_ack, dma_ack, bus_err;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata, bus_rdata;
    logic        bus_we, bus_re, bus_ack;

    mem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_dbl_byte_en(cpu_dbl_byte_en),
        .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_dbl_byte_en(dma_dbl_byte_en),
        .dma_write_en(dma_write_en), .dma_read_en(dma_read_en),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_err(bus_err), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    typedef struct {
        bit          own;
        logic [15:0] rd;
        bit          chk_rd;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [23:0] wlog[$];
    logic [7:0]  mem [0:65535];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          re_cnt = 0;
    int          bus_wait = 0;
    bit          no_ack = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Bus memory model: acks after bus_wait idle cycles per byte.
    initial begin
        int wcnt;
        wcnt      = 0;
        bus_ack   = 1'b0;
        bus_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (nrst && (bus_re || bus_we) && !no_ack && wcnt >= bus_wait) begin
                bus_ack   = 1'b1;
                bus_rdata = mem[bus_addr];
                if (bus_we) begin
                    wlog.push_back({bus_addr, bus_wdata});
                    mem[bus_addr] = bus_wdata;
                end
                wcnt = 0;
            end else begin
                bus_ack   = 1'b0;
                bus_rdata = 8'h00;
                if (bus_re || bus_we) wcnt++;
                else wcnt = 0;
            end
        end
    end

    // Monitor: every ack pops one expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_re) re_cnt++;
            if (cpu_ack || dma_ack) begin
                chk("single_ack", {31'd0, cpu_ack & dma_ack}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: cpu_ack=%0b dma_ack=%0b with no expected entry (cycle %0d)",
                             cpu_ack, dma_ack, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ack_owner", {31'd0, dma_ack}, {31'd0, e.own});
                    chk("ack_err", {31'd0, bus_err}, {31'd0, e.err});
                    if (e.chk_rd) chk("ack_rdata", {16'd0, e.own ? dma_rdata : cpu_rdata}, {16'd0, e.rd});
                    chk("ack_cycle", cyc, e.cyc);
                end
            end else if (bus_err) begin
                chk("stray_err", {31'd0, bus_err}, 32'd0);
            end
        end
    end

    task automatic set_req(input bit own, input logic [15:0] a, input logic [15:0] wd,
                           input bit dbl, input bit we, input bit re);
        if (!own) begin
            cpu_addr = a; cpu_wdata = wd; cpu_dbl_byte_en = dbl;
            cpu_write_en = we; cpu_read_en = re;
        end else begin
            dma_addr = a; dma_wdata = wd; dma_dbl_byte_en = dbl;
            dma_write_en = we; dma_read_en = re;
        end
    endtask

    task automatic wait_ack(input bit own);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(own ? dma_ack : cpu_ack) && n < 60);
        if (!(own ? dma_ack : cpu_ack)) begin
            checks++;
            errors++;
            $display("FAIL ack_wait: no ack on port %0d within %0d cycles", own, n);
        end
    endtask

    task automatic push(input bit own, input logic [15:0] rd, input bit chk_rd,
                        input bit err, input int c);
        exp_t e;
        e.own = own; e.rd = rd; e.chk_rd = chk_rd; e.err = err; e.cyc = c;
        sb.push_back(e);
    endtask

    // One transaction issued in an IDLE cycle; lat = ack cycle relative to it.
    task automatic txn(input bit own, input logic [15:0] a, input logic [15:0] wd,
                       input bit dbl, input bit we, input bit re,
                       input logic [15:0] rd, input bit chk_rd, input bit err, input int lat);
        @(negedge clk);
        push(own, rd, chk_rd, err, cyc + lat);
        set_req(own, a, wd, dbl, we, re);
        wait_ack(own);
        set_req(own, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Both ports read continuously, n reads each; CPU expected to win the tie.
    task automatic tie(input int n);
        int c0;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < n; i++) begin
            push(1'b0, 16'h00C0 + 16'(i), 1'b1, 1'b0, c0 + 2 + 6 * i);
            push(1'b1, 16'h00D0 + 16'(i), 1'b1, 1'b0, c0 + 5 + 6 * i);
        end
        fork
            begin
                set_req(1'b0, 16'h2000, 16'h0, 1'b0, 1'b0, 1'b1);
                for (int i = 0; i < n; i++) begin
                    wait_ack(1'b0);
                    cpu_addr = 16'h2000 + 16'(i + 1);
                end
                set_req(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            end
            begin
                set_req(1'b1, 16'h3000, 16'h0, 1'b0, 1'b0, 1'b1);
                for (int i = 0; i < n; i++) begin
                    wait_ack(1'b1);
                    dma_addr = 16'h3000 + 16'(i + 1);
                end
                set_req(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
            end
        join
    endtask

    initial begin
        nrst = 1'b0;
        set_req(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        set_req(1'b1, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h1000] = 8'h3E;
        mem[16'h1234] = 8'hA5;
        mem[16'hFFFF] = 8'h22;
        mem[16'h0000] = 8'h43;
        for (int i = 0; i < 3; i++) begin
            mem[16'h2000 + 16'(i)] = 8'hC0 + 8'(i);
            mem[16'h3000 + 16'(i)] = 8'hD0 + 8'(i);
        end

        repeat (2) @(negedge clk);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_dma_ack", {31'd0, dma_ack}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_strobes", {30'd0, bus_we, bus_re}, 32'd0);
        chk("rst_bus_addr", {16'd0, bus_addr}, 32'd0);
        chk("rst_bus_wdata", {24'd0, bus_wdata}, 32'd0);
        chk("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
        nrst = 1'b1;

        tie(3);

        txn(1'b0, 16'h1000, 16'h0, 1'b0, 1'b0, 1'b1, 16'h003E, 1'b1, 1'b0, 2);

        wlog.delete();
        txn(1'b0, 16'hFEFE, 16'h1003, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 3);
        chk("wr_byte_count", wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            chk("wr_byte0", {8'd0, wlog[0]}, 32'h00FEFE03);
            chk("wr_byte1", {8'd0, wlog[1]}, 32'h00FEFF10);
        end

        // Ack in the very cycle the watchdog would expire: success.
        bus_wait = 3;
        txn(1'b0, 16'h1234, 16'h0, 1'b0, 1'b0, 1'b1, 16'h00A5, 1'b1, 1'b0, 5);
        bus_wait = 0;

        txn(1'b1, 16'hFFFF, 16'h0, 1'b1, 1'b0, 1'b1, 16'h4322, 1'b1, 1'b0, 3);
        chk("cpu_rdata_hold", {16'd0, cpu_rdata}, 32'h000000A5);

        no_ack = 1'b1;
        re_cnt = 0;
        txn(1'b0, 16'h1000, 16'h0, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 5);
        chk("timeout_strobe_cycles", re_cnt, 32'd4);
        no_ack = 1'b0;

        // Reset while the second byte of a 16-bit write is on the bus.
        @(negedge clk);
        set_req(1'b0, 16'h4000, 16'hABCD, 1'b1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("hi_we", {31'd0, bus_we}, 32'd1);
        chk("hi_addr", {16'd0, bus_addr}, 32'h00004001);
        nrst = 1'b0;
        #1;
        chk("rst_hi_strobes", {30'd0, bus_we, bus_re}, 32'd0);
        set_req(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        wlog.delete();

        tie(1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
